// File: rtl/pong_ai_driver_if.sv
// Signal bundle between the Pong ball/paddle logic and the computer-opponent driver.
// The master side supplies ball/paddle state and controls; the slave (AI driver) returns the key code.
interface pong_ai_driver_if;
   logic       enable;
   logic       guiwei;
   logic [9:0] ball_y;
   logic       ball_dir;
   logic [9:0] paddle_y;
   logic [1:0] key;
   logic [1:0] ai_state;

   modport master (
      output enable, guiwei, ball_y, ball_dir, paddle_y,
      input  key, ai_state
   );

   modport slave (
      input  enable, guiwei, ball_y, ball_dir, paddle_y,
      output key, ai_state
   );
endinterface

// File: rtl/pong_ai_driver.sv
// Computer-opponent paddle controller producing the active-low button code a human player would.
// Optional reaction delay (WAIT state plus react counter) is built only when AI_REACT_DELAY_EN is defined.
module pong_ai_driver #(
   parameter logic        SIDE         = 1'b0,
   parameter logic [9:0]  PADDLE_L     = 10'd80,
   parameter logic [9:0]  BALL_W       = 10'd10,
   parameter logic [9:0]  CENTER_Y     = 10'd200,
   parameter logic [9:0]  DEAD         = 10'd4,
   parameter logic [21:0] DIV          = 22'd50000,
   parameter logic [21:0] REACT_CYCLES = 22'd2000000
) (
   input  logic            vga_clk,
   input  logic            sys_rst_n,
   pong_ai_driver_if.slave ai
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      TRACK = 2'd2
   } state_t;

   localparam logic [10:0] HALF_PADDLE = {2'b00, PADDLE_L[9:1]};
   localparam logic [10:0] HALF_BALL   = {2'b00, BALL_W[9:1]};
   localparam logic [10:0] PARK_C      = {1'b0, CENTER_Y} + HALF_PADDLE;

   state_t             state;
   logic [21:0]        tick_cnt;
   logic               tick;
   logic               appr;
   logic               force_hold;
   logic [10:0]        bc_p0;
   logic [10:0]        pc_p0;
   logic [10:0]        target_p0;
   logic signed [11:0] err_p0;
   logic [1:0]         key_nxt_p0;
   logic [1:0]         key_p1;

`ifdef AI_REACT_DELAY_EN
   logic [21:0]        react_cnt;
`else
   logic               unused_react;
   assign unused_react = ^REACT_CYCLES;
`endif

   // Dead-band decode: strictly outside +/-DEAD moves, the band edges themselves hold.
   function automatic logic [1:0] key_decode(input logic signed [11:0] err,
                                             input logic [9:0]         dead);
      logic signed [11:0] d;
      d = $signed({2'b00, dead});
      if (err > d)
         key_decode = 2'b10;
      else if (err < -d)
         key_decode = 2'b01;
      else
         key_decode = 2'b11;
   endfunction

   // Stage p0: centres, error and candidate key from the current state and inputs
   always_comb begin
      appr       = (ai.ball_dir == SIDE);
      force_hold = ai.guiwei | ~ai.enable;
      tick       = (tick_cnt == DIV - 22'd1);
      bc_p0      = {1'b0, ai.ball_y} + HALF_BALL;
      pc_p0      = {1'b0, ai.paddle_y} + HALF_PADDLE;
      target_p0  = (state == TRACK) ? bc_p0 : PARK_C;
      err_p0     = $signed({1'b0, target_p0}) - $signed({1'b0, pc_p0});
      key_nxt_p0 = key_decode(err_p0, DEAD);
`ifdef AI_REACT_DELAY_EN
      if (state == WAIT)
         key_nxt_p0 = 2'b11;
`endif
   end

   // Stage p1: state machine, tick divider and registered key
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         key_p1    <= 2'b11;
`ifdef AI_REACT_DELAY_EN
         react_cnt <= '0;
`endif
      end else if (force_hold) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         key_p1    <= 2'b11;
`ifdef AI_REACT_DELAY_EN
         react_cnt <= '0;
`endif
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 22'd1;
         if (tick)
            key_p1 <= key_nxt_p0;
         case (state)
            IDLE: begin
               if (appr) begin
`ifdef AI_REACT_DELAY_EN
                  state <= WAIT;
`else
                  state <= TRACK;
`endif
               end
            end
`ifdef AI_REACT_DELAY_EN
            // A receding ball wins over an expiring count, and always restarts the delay.
            WAIT: begin
               if (!appr) begin
                  state     <= IDLE;
                  react_cnt <= '0;
               end else if (react_cnt == REACT_CYCLES - 22'd1) begin
                  state     <= TRACK;
                  react_cnt <= '0;
               end else begin
                  react_cnt <= react_cnt + 22'd1;
               end
            end
`endif
            TRACK: begin
               if (!appr)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ai.key      = key_p1;
   assign ai.ai_state = state;

endmodule

// File: tb/tb_pong_ai_driver.sv
// Scoreboard bench for pong_ai_driver: expectations are queued with their clock offsets and checked as the DUT advances.
// Runs in either build; the reaction-delay scenario is selected by AI_REACT_DELAY_EN.
module tb_pong_ai_driver;

   localparam logic [21:0] DIV   = 22'd4;
   localparam logic [21:0] REACT = 22'd10;
   localparam int          TICKW = int'(DIV) + 1;
`ifdef AI_REACT_DELAY_EN
   localparam int          SETTLE   = int'(REACT) + int'(DIV) + 3;
   localparam logic [1:0]  ENTER_ST = 2'd1;
`else
   localparam int          SETTLE   = int'(DIV) + 2;
   localparam logic [1:0]  ENTER_ST = 2'd2;
`endif

   typedef struct {
      string      name;
      int         steps;
      logic [1:0] key;
      logic [1:0] st;
      bit         key_chk;
   } exp_t;

   logic vga_clk = 1'b0;
   logic sys_rst_n;
   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   pong_ai_driver_if ai ();

   pong_ai_driver #(
      .SIDE(1'b0), .PADDLE_L(10'd80), .BALL_W(10'd10), .CENTER_Y(10'd200),
      .DEAD(10'd4), .DIV(DIV), .REACT_CYCLES(REACT)
   ) dut (
      .vga_clk  (vga_clk),
      .sys_rst_n(sys_rst_n),
      .ai       (ai)
   );

   always #5 vga_clk = ~vga_clk;

   function automatic exp_t mk(string n, int s, logic [1:0] k, logic [1:0] st, bit kc);
      exp_t e;
      e.name = n; e.steps = s; e.key = k; e.st = st; e.key_chk = kc;
      return e;
   endfunction

   task automatic step();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      for (int ph = 0; ph < 3; ph++) begin
         case (ph)
            0: begin
               sys_rst_n = 1'b0;
               ai.enable = 1'b1; ai.guiwei = 1'b0; ai.ball_dir = 1'b1;
               ai.ball_y = 10'd100; ai.paddle_y = 10'd50;
               repeat (3) @(posedge vga_clk);
               #1;
               exp_q.push_back(mk("rst_asserted", 0, 2'b11, 2'd0, 1'b1));
            end
            1: begin
               @(negedge vga_clk);
               sys_rst_n = 1'b1;
               for (int i = 0; i < 3; i++)
                  exp_q.push_back(mk("rst_before_tick", 1, 2'b11, 2'd0, 1'b1));
               exp_q.push_back(mk("rst_first_tick", 1, 2'b10, 2'd0, 1'b1));
               exp_q.push_back(mk("rst_key_stable", 1, 2'b10, 2'd0, 1'b1));
            end
            default: begin
               sys_rst_n = 1'b0;
               #2;
               exp_q.push_back(mk("rst_async", 0, 2'b11, 2'd0, 1'b1));
            end
         endcase
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            repeat (e.steps) step();
            vectors++;
            if (ai.ai_state !== e.st || (e.key_chk && ai.key !== e.key)) begin
               miscompares++;
               $display("FAIL %s: got key=%b state=%0d, required key=%b state=%0d",
                        e.name, ai.key, ai.ai_state, e.key, e.st);
            end
         end
      end
      @(negedge vga_clk);
      sys_rst_n = 1'b1;
      step();
   endtask

`ifdef AI_REACT_DELAY_EN
   task automatic test_react_delay();
      exp_t e;
      for (int ph = 0; ph < 5; ph++) begin
         case (ph)
            0: begin
               ai.ball_dir = 1'b1; ai.paddle_y = 10'd200; ai.ball_y = 10'd300;
               exp_q.push_back(mk("idle_parked", TICKW, 2'b11, 2'd0, 1'b1));
            end
            1: begin
               ai.ball_dir = 1'b0;
               for (int i = 0; i < 10; i++)
                  exp_q.push_back(mk("wait_full", 1, 2'b11, 2'd1, 1'b1));
               exp_q.push_back(mk("wait_expire", 1, 2'b11, 2'd2, 1'b0));
               exp_q.push_back(mk("wait_then_track", TICKW, 2'b10, 2'd2, 1'b1));
            end
            2: begin
               ai.ball_dir = 1'b1;
               exp_q.push_back(mk("track_recede", 1, 2'b11, 2'd0, 1'b0));
               exp_q.push_back(mk("idle_parked2", TICKW, 2'b11, 2'd0, 1'b1));
               exp_q.push_back(mk("pre_abort", 1, 2'b11, 2'd0, 1'b1));
            end
            3: begin
               ai.ball_dir = 1'b0;
               for (int i = 0; i < 5; i++)
                  exp_q.push_back(mk("wait_partial", 1, 2'b11, 2'd1, 1'b1));
            end
            default: begin
               ai.ball_dir = 1'b1;
               exp_q.push_back(mk("wait_abort", 1, 2'b11, 2'd0, 1'b1));
               exp_q.push_back(mk("abort_idle", 1, 2'b11, 2'd0, 1'b1));
            end
         endcase
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            repeat (e.steps) step();
            vectors++;
            if (ai.ai_state !== e.st || (e.key_chk && ai.key !== e.key)) begin
               miscompares++;
               $display("FAIL %s: got key=%b state=%0d, required key=%b state=%0d",
                        e.name, ai.key, ai.ai_state, e.key, e.st);
            end
         end
      end
      // A fresh approach after an abort must run the whole delay again.
      ai.ball_dir = 1'b0;
      for (int i = 0; i < 10; i++)
         exp_q.push_back(mk("wait_restart", 1, 2'b11, 2'd1, 1'b1));
      exp_q.push_back(mk("restart_expire", 1, 2'b11, 2'd2, 1'b0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         repeat (e.steps) step();
         vectors++;
         if (ai.ai_state !== e.st || (e.key_chk && ai.key !== e.key)) begin
            miscompares++;
            $display("FAIL %s: got key=%b state=%0d, required key=%b state=%0d",
                     e.name, ai.key, ai.ai_state, e.key, e.st);
         end
      end
      ai.ball_dir = 1'b1;
      step();
   endtask
`else
   task automatic test_direct_track();
      exp_t e;
      ai.ball_dir = 1'b0; ai.paddle_y = 10'd200; ai.ball_y = 10'd300;
      exp_q.push_back(mk("direct_track", 1, 2'b11, 2'd2, 1'b0));
      for (int i = 0; i < 12; i++)
         exp_q.push_back(mk("never_wait", 1, 2'b11, 2'd2, 1'b0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         repeat (e.steps) step();
         vectors++;
         if (ai.ai_state !== e.st || (e.key_chk && ai.key !== e.key)) begin
            miscompares++;
            $display("FAIL %s: got key=%b state=%0d, required key=%b state=%0d",
                     e.name, ai.key, ai.ai_state, e.key, e.st);
         end
      end
      ai.ball_dir = 1'b1;
      step();
   endtask
`endif

   task automatic test_track();
      exp_t e;
      for (int ph = 0; ph < 6; ph++) begin
         case (ph)
            0: begin
               ai.ball_dir = 1'b0; ai.paddle_y = 10'd200; ai.ball_y = 10'd300;
               exp_q.push_back(mk("track_enter", 1, 2'b11, ENTER_ST, 1'b0));
               exp_q.push_back(mk("track_down", SETTLE, 2'b10, 2'd2, 1'b1));
            end
            1: begin
               ai.ball_y = 10'd100;
               exp_q.push_back(mk("track_up", TICKW, 2'b01, 2'd2, 1'b1));
            end
            2: begin
               ai.ball_y = 10'd239;
               exp_q.push_back(mk("dead_plus4", TICKW, 2'b11, 2'd2, 1'b1));
            end
            3: begin
               ai.ball_y = 10'd240;
               exp_q.push_back(mk("dead_plus5", TICKW, 2'b10, 2'd2, 1'b1));
            end
            4: begin
               ai.ball_y = 10'd231;
               exp_q.push_back(mk("dead_minus4", TICKW, 2'b11, 2'd2, 1'b1));
            end
            default: begin
               ai.ball_y = 10'd230;
               exp_q.push_back(mk("dead_minus5", TICKW, 2'b01, 2'd2, 1'b1));
            end
         endcase
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            repeat (e.steps) step();
            vectors++;
            if (ai.ai_state !== e.st || (e.key_chk && ai.key !== e.key)) begin
               miscompares++;
               $display("FAIL %s: got key=%b state=%0d, required key=%b state=%0d",
                        e.name, ai.key, ai.ai_state, e.key, e.st);
            end
         end
      end
   endtask

   task automatic test_centre();
      exp_t e;
      for (int ph = 0; ph < 5; ph++) begin
         case (ph)
            0: begin
               ai.ball_dir = 1'b1;
               exp_q.push_back(mk("recede_idle", 1, 2'b11, 2'd0, 1'b0));
            end
            1: begin
               ai.paddle_y = 10'd50;
               exp_q.push_back(mk("centre_down", TICKW, 2'b10, 2'd0, 1'b1));
            end
            2: begin
               ai.paddle_y = 10'd196;
               exp_q.push_back(mk("centre_band", TICKW, 2'b11, 2'd0, 1'b1));
            end
            3: begin
               ai.paddle_y = 10'd195;
               exp_q.push_back(mk("centre_edge5", TICKW, 2'b10, 2'd0, 1'b1));
            end
            default: begin
               ai.paddle_y = 10'd300;
               exp_q.push_back(mk("centre_up", TICKW, 2'b01, 2'd0, 1'b1));
            end
         endcase
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            repeat (e.steps) step();
            vectors++;
            if (ai.ai_state !== e.st || (e.key_chk && ai.key !== e.key)) begin
               miscompares++;
               $display("FAIL %s: got key=%b state=%0d, required key=%b state=%0d",
                        e.name, ai.key, ai.ai_state, e.key, e.st);
            end
         end
      end
   endtask

   task automatic test_force_hold();
      exp_t e;
      for (int ph = 0; ph < 5; ph++) begin
         case (ph)
            0: begin
               ai.ball_dir = 1'b0; ai.paddle_y = 10'd200; ai.ball_y = 10'd300;
               exp_q.push_back(mk("pre_guiwei", SETTLE, 2'b10, 2'd2, 1'b1));
               exp_q.push_back(mk("pre_guiwei_off_tick", 2, 2'b10, 2'd2, 1'b1));
            end
            1: begin
               ai.guiwei = 1'b1;
               for (int i = 0; i < 6; i++)
                  exp_q.push_back(mk("guiwei_hold", 1, 2'b11, 2'd0, 1'b1));
            end
            2: begin
               ai.guiwei = 1'b0;
               exp_q.push_back(mk("guiwei_release", SETTLE, 2'b10, 2'd2, 1'b1));
               exp_q.push_back(mk("pre_disable_off_tick", 1, 2'b10, 2'd2, 1'b1));
            end
            3: begin
               ai.enable = 1'b0;
               for (int i = 0; i < 6; i++)
                  exp_q.push_back(mk("disable_hold", 1, 2'b11, 2'd0, 1'b1));
            end
            default: begin
               ai.enable = 1'b1;
               exp_q.push_back(mk("enable_back", SETTLE, 2'b10, 2'd2, 1'b1));
            end
         endcase
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            repeat (e.steps) step();
            vectors++;
            if (ai.ai_state !== e.st || (e.key_chk && ai.key !== e.key)) begin
               miscompares++;
               $display("FAIL %s: got key=%b state=%0d, required key=%b state=%0d",
                        e.name, ai.key, ai.ai_state, e.key, e.st);
            end
         end
      end
   endtask

   initial begin
      test_reset();
`ifdef AI_REACT_DELAY_EN
      test_react_delay();
`else
      test_direct_track();
`endif
      test_track();
      test_centre();
      test_force_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
